// File: rtl/regfile32.sv
// regfile32: 31 x WIDTH register file, R0 hardwired to zero, two combinational read ports, wrapping write counter.
// Define REGFILE32_BYPASS_EN to forward same-cycle write data onto matching read ports.
module regfile32 #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             We,
    input  logic [4:0]       Wn,
    input  logic [WIDTH-1:0] D,
    input  logic [4:0]       Rna,
    input  logic [4:0]       Rnb,
    output logic [WIDTH-1:0] Qa,
    output logic [WIDTH-1:0] Qb,
    output logic [7:0]       Wcnt
);
    logic [31:0]      sel;
    logic [WIDTH-1:0] rd [0:31];
    logic             commit;

    assign sel    = We ? (32'd1 << Wn) : 32'd0;
    assign commit = |sel[31:1];
    assign rd[0]  = '0;

    for (genvar r = 1; r < 32; r++) begin : g_reg
        logic [WIDTH-1:0] q;
        always_ff @(posedge Clk or posedge Rst)
            if (Rst)
                q <= '0;
            else if (sel[r])
                q <= D;
        assign rd[r] = q;
    end

    always_ff @(posedge Clk or posedge Rst)
        if (Rst)
            Wcnt <= '0;
        else if (commit)
            Wcnt <= Wcnt + 8'd1;

    // Reads are forced to zero during reset so a pending write can never leak through.
`ifdef REGFILE32_BYPASS_EN
    assign Qa = Rst ? '0 : (sel[Rna] && Rna != 5'd0) ? D : rd[Rna];
    assign Qb = Rst ? '0 : (sel[Rnb] && Rnb != 5'd0) ? D : rd[Rnb];
`else
    assign Qa = Rst ? '0 : rd[Rna];
    assign Qb = Rst ? '0 : rd[Rnb];
`endif
endmodule
